bnn_threshold_packer: RTL and testbench

//  Downstream stage of accelerator_top. On each accelerator done, captures the NUM_PES x ACC_W

---
 rtl/bnn_threshold_packer.sv | 125 ++++++++++++
 tb/tb_bnn_threshold_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_threshold_packer.sv
// Binarizes an accelerator popcount vector against per-neuron thresholds (folded batch-norm)
// and hands the packed activation word to the next layer over a valid/ready port.
module bnn_threshold_packer #(
    parameter int NUM_PES = 64,
    parameter int ACC_W   = 16,
    parameter int LANES   = 8,
    parameter int ADDR_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     acc_done,
    input  logic [NUM_PES*ACC_W-1:0] results_in,
    input  logic                     thr_wr_en,
    input  logic [ADDR_W-1:0]        thr_wr_idx,
    input  logic [ACC_W-1:0]         thr_wr_data,
    input  logic                     thr_wr_inv,
    input  logic                     cfg_addr_load,
    input  logic [ADDR_W-1:0]        cfg_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_PES-1:0]       out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     overrun
);

    localparam int GROUPS = NUM_PES / LANES;
    localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, OUTPUT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   cap_buf [NUM_PES];
    logic [ACC_W-1:0]   thr_mem [NUM_PES];
    logic [NUM_PES-1:0] inv_mem;
    logic [NUM_PES-1:0] pack_reg;
    logic [NUM_PES-1:0] next_pack;

    function automatic logic [ADDR_W-1:0] lane_neuron(input int lane);
        return ADDR_W'(int'(idx) * LANES + lane);
    endfunction

    function automatic logic lane_bit(input logic [ADDR_W-1:0] n);
        return inv_mem[n] ? (cap_buf[n] < thr_mem[n]) : (cap_buf[n] >= thr_mem[n]);
    endfunction

    always_comb begin
        next_pack = pack_reg;
        for (int l = 0; l < LANES; l++) begin
            next_pack[lane_neuron(l)] = lane_bit(lane_neuron(l));
        end
    end

    // Threshold writes are only honoured in IDLE so a running job sees a frozen table.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PES; i++) begin
                thr_mem[ADDR_W'(i)] <= '0;
            end
            inv_mem <= '0;
        end else if (thr_wr_en && state == IDLE) begin
            thr_mem[thr_wr_idx] <= thr_wr_data;
            inv_mem[thr_wr_idx] <= thr_wr_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && acc_done) begin
            for (int i = 0; i < NUM_PES; i++) begin
                cap_buf[ADDR_W'(i)] <= results_in[i*ACC_W +: ACC_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            pack_reg  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (acc_done && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (acc_done) begin
                        idx   <= '0;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    pack_reg <= next_pack;
                    idx      <= idx + 1'b1;
                    if (idx == LAST_GRP) begin
                        out_data  <= next_pack;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // An explicit load overrides the post-handshake increment.
            if (cfg_addr_load) begin
                out_addr <= cfg_addr;
            end else if (state == OUTPUT && out_ready) begin
                out_addr <= out_addr + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bnn_threshold_packer.sv
// Scoreboard bench for bnn_threshold_packer: directed jobs push expected words, a negedge
// monitor pops and compares on every accepted handshake.
module tb_bnn_threshold_packer;

    logic          clk;
    logic          reset_n;
    logic          acc_done;
    logic [1023:0] results_in;
    logic          thr_wr_en;
    logic [5:0]    thr_wr_idx;
    logic [15:0]   thr_wr_data;
    logic          thr_wr_inv;
    logic          cfg_addr_load;
    logic [5:0]    cfg_addr;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [5:0]    out_addr;
    logic          busy;
    logic          overrun;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    bnn_threshold_packer dut (
        .clk(clk), .reset_n(reset_n), .acc_done(acc_done), .results_in(results_in),
        .thr_wr_en(thr_wr_en), .thr_wr_idx(thr_wr_idx), .thr_wr_data(thr_wr_data),
        .thr_wr_inv(thr_wr_inv), .cfg_addr_load(cfg_addr_load), .cfg_addr(cfg_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_word: got %h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_data", out_data, e.data);
                check("word_addr", 64'(out_addr), 64'(e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] uniform(input logic [15:0] v);
        return {64{v}};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic write_thr(input int n, input logic [15:0] v, input logic inv);
        thr_wr_en   = 1'b1;
        thr_wr_idx  = 6'(n);
        thr_wr_data = v;
        thr_wr_inv  = inv;
        tick();
        thr_wr_en   = 1'b0;
    endtask

    task automatic start_job(input logic [1023:0] pops);
        acc_done   = 1'b1;
        results_in = pops;
        tick();
        acc_done   = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic run_job(input logic [1023:0] pops, input logic [63:0] d, input logic [5:0] a);
        int n;
        sb.push_back('{data: d, addr: a});
        start_job(pops);
        wait_valid(n);
        check("latency", 64'(n), 64'd8);
        wait_idle();
    endtask

    initial begin
        int n;
        logic [1023:0] vec;
        reset_n = 1'b0; acc_done = 1'b0; results_in = '0;
        thr_wr_en = 1'b0; thr_wr_idx = '0; thr_wr_data = '0; thr_wr_inv = 1'b0;
        cfg_addr_load = 1'b0; cfg_addr = '0; out_ready = 1'b1;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] reset mid-compare");
        start_job(uniform(16'd0));
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        run_job(uniform(16'd0), ONES, 6'd0);

        $display("[TB] identity run");
        do_reset();
        for (int i = 0; i < 64; i++) write_thr(i, 16'd32, 1'b0);
        sb.push_back('{data: ONES, addr: 6'd0});
        start_job(uniform(16'd32));
        wait_valid(n);
        check("id_latency", 64'(n), 64'd8);
        check("id_addr_out", 64'(out_addr), 64'd0);
        wait_idle();
        check("id_addr_next", 64'(out_addr), 64'd1);

        $display("[TB] boundary and flip");
        for (int i = 0; i < 64; i += 2) write_thr(i, 16'd33, (i == 0));
        run_job(uniform(16'd32), 64'hAAAA_AAAA_AAAA_AAAB, 6'd1);
        write_thr(5, 16'hFFFF, 1'b0);
        vec = '0;
        vec[5*16 +: 16] = 16'hFFFF;
        run_job(vec, 64'h0000_0000_0000_0021, 6'd2);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        sb.push_back('{data: 64'hAAAA_AAAA_AAAA_AA8B, addr: 6'd3});
        start_job(uniform(16'd32));
        wait_valid(n);
        check("bp_overrun_pre", 64'(overrun), 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                acc_done   = 1'b1;
                results_in = uniform(16'd0);
            end
            tick();
            acc_done = 1'b0;
            check("bp_data", out_data, 64'hAAAA_AAAA_AAAA_AA8B);
            check("bp_addr", 64'(out_addr), 64'd3);
            check("bp_busy", 64'(busy), 64'd1);
        end
        check("bp_overrun", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        wait_idle();

        $display("[TB] address counter");
        do_reset();
        check("overrun_cleared", 64'(overrun), 64'd0);
        cfg_addr = 6'd63;
        cfg_addr_load = 1'b1;
        tick();
        cfg_addr_load = 1'b0;
        check("addr_loaded", 64'(out_addr), 64'd63);
        run_job(uniform(16'd0), ONES, 6'd63);
        run_job(uniform(16'd0), ONES, 6'd0);
        out_ready = 1'b0;
        sb.push_back('{data: ONES, addr: 6'd1});
        start_job(uniform(16'd0));
        wait_valid(n);
        cfg_addr = 6'd5;
        cfg_addr_load = 1'b1;
        out_ready = 1'b1;
        tick();
        cfg_addr_load = 1'b0;
        check("load_wins", 64'(out_addr), 64'd5);
        check("load_hs_idle", 64'(busy), 64'd0);

        $display("[TB] threshold write while busy");
        do_reset();
        write_thr(3, 16'd1, 1'b0);
        sb.push_back('{data: 64'hFFFF_FFFF_FFFF_FFF7, addr: 6'd0});
        start_job(uniform(16'd0));
        tick();
        write_thr(3, 16'd0, 1'b0);
        wait_valid(n);
        wait_idle();
        run_job(uniform(16'd0), 64'hFFFF_FFFF_FFFF_FFF7, 6'd1);
        write_thr(3, 16'd0, 1'b0);
        run_job(uniform(16'd0), ONES, 6'd2);
        thr_wr_en = 1'b1; thr_wr_idx = 6'd7; thr_wr_data = 16'd1; thr_wr_inv = 1'b0;
        sb.push_back('{data: 64'hFFFF_FFFF_FFFF_FF7F, addr: 6'd3});
        start_job(uniform(16'd0));
        thr_wr_en = 1'b0;
        wait_valid(n);
        wait_idle();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
